// File: rtl/snake_game_ctrl.sv
// Game-flow controller: steps the snake core, scans the body for collisions,
// scores apples and places new ones by rejection sampling against the body.
module snake_game_ctrl #(
    parameter  int GRID_W    = 64,
    parameter  int GRID_H    = 48,
    parameter  int MAX_LEN   = 32,
    parameter  int MAX_TRIES = 8,
    parameter  int APPLE_X0  = 40,
    parameter  int APPLE_Y0  = 24,
    localparam int IW        = $clog2(MAX_LEN)
) (
    input  logic          clk_pix,
    input  logic          reset_n,
    input  logic          tick,
    input  logic          start_btn,
    input  logic [15:0]   rnd,
    input  logic [7:0]    snake_len,
    input  logic [5:0]    head_gx,
    input  logic [5:0]    head_gy,
    output logic [IW-1:0] seg_idx,
    input  logic [5:0]    seg_gx,
    input  logic [5:0]    seg_gy,
    output logic          step_en,
    output logic          grow,
    output logic          snake_clr,
    output logic [5:0]    apple_gx,
    output logic [5:0]    apple_gy,
    output logic          apple_valid,
    output logic [7:0]    score,
    output logic          playing,
    output logic          game_over
);
    localparam int TW = $clog2(MAX_TRIES + 1);

    typedef enum logic [3:0] {
        IDLE,
        WAIT_TICK,
        STEP,
        SETTLE,
        SCAN_SELF,
        CHK_APPLE,
        PLACE_GEN,
        PLACE_SCAN,
        OVER
    } state_t;

    state_t        state, state_nx;
    logic          start_btn_d;
    logic [IW-1:0] seg_idx_nx;
    logic [5:0]    apple_gx_nx, apple_gy_nx;
    logic [5:0]    cand_x, cand_y, cand_x_nx, cand_y_nx;
    logic          apple_valid_nx, playing_nx, game_over_nx;
    logic          snake_clr_nx;
    logic [7:0]    score_nx;
    logic          grow_pend, grow_pend_nx;
    logic          tick_pend, tick_pend_nx;
    logic          place_pend, place_pend_nx;
    logic [TW-1:0] try_cnt, try_cnt_nx;

    logic          start_rise, restart;
    logic          seg_last, hit_head, hit_cand, on_apple;
    logic [5:0]    gen_x, gen_y;
    logic          gen_ok;
    logic          unused_rnd;

    assign start_rise = start_btn & ~start_btn_d;
    assign seg_last   = (8'(seg_idx) == snake_len - 8'd1);
    assign hit_head   = (seg_gx == head_gx) && (seg_gy == head_gy);
    assign hit_cand   = (seg_gx == cand_x) && (seg_gy == cand_y);
    assign on_apple   = (head_gx == apple_gx) && (head_gy == apple_gy);
    assign gen_x      = 6'(32'(rnd[5:0]) % 32'(GRID_W));
    assign gen_y      = rnd[11:6];
    assign gen_ok     = ({26'd0, gen_y} < 32'(GRID_H));
    assign unused_rnd = ^rnd[15:12];

    assign step_en = (state == STEP);
    assign grow    = step_en & grow_pend;

    always_ff @(posedge clk_pix) begin
        if (!reset_n) begin
            state       <= IDLE;
            start_btn_d <= 1'b1;
            seg_idx     <= '0;
            apple_gx    <= 6'(APPLE_X0);
            apple_gy    <= 6'(APPLE_Y0);
            apple_valid <= 1'b1;
            cand_x      <= '0;
            cand_y      <= '0;
            score       <= '0;
            playing     <= 1'b0;
            game_over   <= 1'b0;
            snake_clr   <= 1'b0;
            grow_pend   <= 1'b0;
            tick_pend   <= 1'b0;
            place_pend  <= 1'b0;
            try_cnt     <= '0;
        end else begin
            state       <= state_nx;
            start_btn_d <= start_btn;
            seg_idx     <= seg_idx_nx;
            apple_gx    <= apple_gx_nx;
            apple_gy    <= apple_gy_nx;
            apple_valid <= apple_valid_nx;
            cand_x      <= cand_x_nx;
            cand_y      <= cand_y_nx;
            score       <= score_nx;
            playing     <= playing_nx;
            game_over   <= game_over_nx;
            snake_clr   <= snake_clr_nx;
            grow_pend   <= grow_pend_nx;
            tick_pend   <= tick_pend_nx;
            place_pend  <= place_pend_nx;
            try_cnt     <= try_cnt_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        seg_idx_nx     = seg_idx;
        apple_gx_nx    = apple_gx;
        apple_gy_nx    = apple_gy;
        apple_valid_nx = apple_valid;
        cand_x_nx      = cand_x;
        cand_y_nx      = cand_y;
        score_nx       = score;
        playing_nx     = playing;
        game_over_nx   = game_over;
        snake_clr_nx   = 1'b0;
        grow_pend_nx   = grow_pend;
        tick_pend_nx   = tick_pend;
        place_pend_nx  = place_pend;
        try_cnt_nx     = try_cnt;
        restart        = 1'b0;

        // A tick that lands mid-step is remembered once, extras are dropped
        if (tick && !(state inside {IDLE, WAIT_TICK, OVER}))
            tick_pend_nx = 1'b1;

        unique case (state)
            IDLE, OVER: restart = start_rise;
            WAIT_TICK: begin
                if (tick || tick_pend) begin
                    state_nx     = STEP;
                    tick_pend_nx = 1'b0;
                end
            end
            STEP: begin
                grow_pend_nx = 1'b0;
                state_nx     = SETTLE;
            end
            SETTLE: begin
                seg_idx_nx = IW'(1);
                state_nx   = (snake_len == 8'd1) ? CHK_APPLE : SCAN_SELF;
            end
            SCAN_SELF: begin
                if (hit_head) begin
                    state_nx     = OVER;
                    playing_nx   = 1'b0;
                    game_over_nx = 1'b1;
                end else if (seg_last) begin
                    state_nx = CHK_APPLE;
                end else begin
                    seg_idx_nx = seg_idx + IW'(1);
                end
            end
            CHK_APPLE: begin
                if (apple_valid && on_apple) begin
                    if (score != 8'hFF)
                        score_nx = score + 8'd1;
                    if (snake_len < 8'(MAX_LEN))
                        grow_pend_nx = 1'b1;
                    apple_valid_nx = 1'b0;
                    try_cnt_nx     = '0;
                    state_nx       = PLACE_GEN;
                end else if (place_pend) begin
                    try_cnt_nx = '0;
                    state_nx   = PLACE_GEN;
                end else begin
                    state_nx = WAIT_TICK;
                end
            end
            PLACE_GEN: begin
                if (try_cnt == TW'(MAX_TRIES)) begin
                    place_pend_nx = 1'b1;
                    state_nx      = WAIT_TICK;
                end else if (!gen_ok) begin
                    try_cnt_nx = try_cnt + TW'(1);
                end else begin
                    cand_x_nx  = gen_x;
                    cand_y_nx  = gen_y;
                    seg_idx_nx = '0;
                    state_nx   = PLACE_SCAN;
                end
            end
            PLACE_SCAN: begin
                if (hit_cand) begin
                    try_cnt_nx = try_cnt + TW'(1);
                    state_nx   = PLACE_GEN;
                end else if (seg_last) begin
                    apple_gx_nx    = cand_x;
                    apple_gy_nx    = cand_y;
                    apple_valid_nx = 1'b1;
                    place_pend_nx  = 1'b0;
                    state_nx       = WAIT_TICK;
                end else begin
                    seg_idx_nx = seg_idx + IW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase

        if (restart) begin
            state_nx       = WAIT_TICK;
            snake_clr_nx   = 1'b1;
            score_nx       = '0;
            apple_gx_nx    = 6'(APPLE_X0);
            apple_gy_nx    = 6'(APPLE_Y0);
            apple_valid_nx = 1'b1;
            playing_nx     = 1'b1;
            game_over_nx   = 1'b0;
            grow_pend_nx   = 1'b0;
            tick_pend_nx   = 1'b0;
            place_pend_nx  = 1'b0;
            try_cnt_nx     = '0;
        end
    end
endmodule
